// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// A start in IDLE or DONE latches the operands; RUN lasts WIDTH cycles and
// DONE presents a one-cycle done pulse. diff/bout change only on entry to DONE
// and hold the last completed result otherwise.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;
    logic             busy_s;
    logic             done_s;
    logic             accept_s;
    logic             last_bit_s;
    logic [1:0]       bit_s;

    // One full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic br);
        logic d;
        logic br_next;
        d       = x ^ y ^ br;
        br_next = (~x & y) | (~(x ^ y) & br);
        return {br_next, d};
    endfunction

    // Acceptance, last-bit detection and the current bit's subtraction.
    always_comb begin
        accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
        last_bit_s = (cnt_r == CW'(WIDTH - 1));
        bit_s      = sub_bit(a_r[cnt_r], b_r[cnt_r], br_r);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start is ignored while in RUN.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so busy/done can be registered.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (next_state_s)
            RUN:     busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Operand latch, bit counter, running borrow and partial result shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            br_r  <= 1'b0;
            cnt_r <= '0;
            res_r <= '0;
        end else if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            br_r  <= bin;
            cnt_r <= '0;
            res_r <= '0;
        end else if (state_r == RUN) begin
            br_r  <= bit_s[1];
            res_r <= {bit_s[0], res_r[WIDTH-1:1]};
            if (!last_bit_s) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            br_r  <= br_r;
            cnt_r <= cnt_r;
        end
    end

    // Result registers: updated only on the transition into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_r <= '0;
            bout_r <= 1'b0;
        end else if ((state_r == RUN) && last_bit_s) begin
            diff_r <= {bit_s[0], res_r[WIDTH-1:1]};
            bout_r <= bit_s[1];
        end else begin
            diff_r <= diff_r;
            bout_r <= bout_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, corner
// sequences (ignored start, mid-run reset, back-to-back), exhaustive WIDTH=2
// and randomized WIDTH=8 operations against an arithmetic reference.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, done2, bout2;
    logic [1:0] a2, b2, diff2;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic; bit WIDTH of the widened result is the borrow.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic br);
        return {1'b0, x} - {1'b0, y} - {8'd0, br};
    endfunction

    function automatic logic [2:0] ref2(input logic [1:0] x, input logic [1:0] y, input logic br);
        return {1'b0, x} - {1'b0, y} - {2'd0, br};
    endfunction

    // One WIDTH=8 operation: checks latency, busy length, result hold and result.
    task automatic run8(input string nm, input logic [7:0] x, input logic [7:0] y,
                        input logic br, input logic [7:0] ed, input logic eb);
        int n;
        int busy_cnt;
        logic hold_ok;
        logic [7:0] prev;
        @(negedge clk);
        start8 = 1'b1; a8 = x; b8 = y; bin8 = br;
        prev = diff8;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        n = 1; busy_cnt = 0; hold_ok = 1'b1;
        while (!done8 && n < 40) begin
            if (busy8) busy_cnt++;
            if (diff8 !== prev) hold_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd9);
        chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({nm, " diff_hold"}, 32'(hold_ok), 32'd1);
        chk({nm, " diff"}, 32'(diff8), 32'(ed));
        chk({nm, " bout"}, 32'(bout8), 32'(eb));
        chk({nm, " done_busy"}, 32'({done8, busy8}), 32'b10);
        @(negedge clk);
        chk({nm, " idle_after"}, 32'({done8, busy8}), 32'b00);
    endtask

    // One WIDTH=2 operation.
    task automatic run2(input logic [1:0] x, input logic [1:0] y, input logic br);
        int n;
        logic [2:0] e;
        e = ref2(x, y, br);
        @(negedge clk);
        start2 = 1'b1; a2 = x; b2 = y; bin2 = br;
        @(negedge clk);
        start2 = 1'b0; a2 = ~x; b2 = ~y; bin2 = ~br;
        n = 1;
        while (!done2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("w2 %0d-%0d-%0d latency", x, y, br), 32'(n), 32'd3);
        chk($sformatf("w2 %0d-%0d-%0d result", x, y, br), 32'({bout2, diff2}), 32'(e));
    endtask

    initial begin
        int n;
        int pulses;
        logic [8:0] e;
        logic [7:0] ra, rb;
        logic rbin;
        total = 0; bad = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0;
        start2 = 1'b0; a2 = 2'd0; b2 = 2'd0; bin2 = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};

        // Reset state while start is also asserted (reset wins).
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h11;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", 32'({busy8, done8, bout8, diff8}), 32'd0);
        start8 = 1'b0;
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                 vecs[i].diff, vecs[i].bout);
        end

        // Ignored start in the 3rd RUN cycle with different operands.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h37; b8 = 8'h12; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                pulses++;
                chk("ign_start diff", 32'({bout8, diff8}), 32'h025);
            end
            @(negedge clk);
        end
        chk("ign_start pulses", 32'(pulses), 32'd1);
        chk("ign_start idle", 32'({busy8, done8}), 32'b00);

        // Reset asserted during the 4th RUN cycle.
        start8 = 1'b1; a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst outputs", 32'({busy8, done8, bout8, diff8}), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8) pulses++;
            @(negedge clk);
        end
        chk("midrst no_done", 32'(pulses), 32'd0);
        run8("after_rst", 8'h20, 8'h01, 1'b0, 8'h1F, 1'b0);

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        @(negedge clk);
        a8 = 8'hA0; b8 = 8'h0A;
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first", 32'({bout8, diff8}), 32'h002);
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b no_idle", 32'({busy8, done8}), 32'b10);
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b spacing", 32'(n), 32'd9);
        chk("b2b second", 32'({bout8, diff8}), 32'h096);
        @(negedge clk);

        // Exhaustive WIDTH=2.
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++)
                    run2(2'(x), 2'(y), 1'(c));

        // Randomized WIDTH=8 against the arithmetic reference.
        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            e = ref8(ra, rb, rbin);
            run8($sformatf("rnd%0d", i), ra, rb, rbin, e[7:0], e[8]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
